// File: rtl/rom_rr_arb_pkg.sv
// Shared types for the ROM round-robin arbiter: ID width helper, in-flight tag, read latency.
// Latency is 2 when ROM_RR_ARB_OUT_REG_EN is defined, otherwise 1.
package rom_rr_arb_pkg;

    localparam int MAX_ID_W = 4;

`ifdef ROM_RR_ARB_OUT_REG_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sized for the largest supported requester count; narrower arbiters truncate.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, wrapping at NUM_REQ.
// Zero latency, no state; grant is one-hot or zero.
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] cidx;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        cidx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Explicit compare keeps non-power-of-two counts inside 0..NUM_REQ-1.
            cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            cidx = cand[IDX_W-1:0];
            if (!any_o && valid_i[cidx]) begin
                any_o         = 1'b1;
                grant_o[cidx] = 1'b1;
                idx_o         = cidx;
            end
        end
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin shares one registered-read ROM among NUM_REQ valid/ready requesters.
// Response LATENCY cycles after grant (1, or 2 with ROM_RR_ARB_OUT_REG_EN); one read/cycle sustained.
// Requests backpressured by withholding ready; responses have no backpressure.
module rom_rr_arbiter
    import rom_rr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_data_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]    gnt;
    logic                  gnt_raw, gnt_any;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    tag_t                  tag_q [LATENCY];
    tag_t                  tag_out;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_grant (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_raw)
    );

    assign gnt_any     = gnt_raw & arst_n_i;
    assign req_ready_o = gnt & {NUM_REQ{arst_n_i}};
    assign rom_addr_o  = gnt_any ? req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : addr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ptr_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            if (gnt_any) begin
                addr_q <= rom_addr_o;
            end
            // Doubles as the hold register and, when enabled, the output data register.
            if (tag_q[0].valid) begin
                data_q <= rom_data_i;
            end
            tag_q[0].valid <= gnt_any;
            if (gnt_any) begin
                tag_q[0].id <= MAX_ID_W'(gnt_idx);
            end
            for (int s = 1; s < LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tag_out     = tag_q[LATENCY-1];
    assign rsp_valid_o = tag_out.valid ? (NUM_REQ'(1) << tag_out.id) : '0;
    assign rsp_id_o    = ID_W'(tag_out.id);

`ifdef ROM_RR_ARB_OUT_REG_EN
    assign rsp_data_o = data_q;
`else
    assign rsp_data_o = tag_q[0].valid ? rom_data_i : data_q;
`endif

endmodule
